// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter in front of a single-ported RAM.
// Each granted access takes three cycles: IDLE (arbitrate), ACCESS (drive the
// RAM and capture read data), RESP (one-cycle ack/err to the winner).
module ram_arbiter #(
   parameter int MEM_DEPTH = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req_i,
   input  logic        m0_we_i,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m0_data_i,
   output logic [31:0] m0_data_o,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   input  logic        m1_req_i,
   input  logic        m1_we_i,
   input  logic [31:0] m1_addr_i,
   input  logic [31:0] m1_data_i,
   output logic [31:0] m1_data_o,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic        ram_we_o,
   output logic [31:0] ram_addr_o,
   output logic [31:0] ram_data_o,
   input  logic [31:0] ram_data_i
);

   localparam logic [31:0] DEPTH_WORDS = 32'(MEM_DEPTH);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state, state_next;
   logic        winner, winner_next;
   logic        last_grant;
   logic        err_q;

   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_data;
   logic        sel_valid;
   logic        in_access;
   logic [31:0] capture;

   // Next-state logic; on a tie the master not served last wins.
   always_comb begin
      state_next  = state;
      winner_next = winner;
      case (state)
         IDLE: begin
            if (m0_req_i || m1_req_i) begin
               state_next = ACCESS;
               if (m0_req_i && m1_req_i) begin
                  winner_next = ~last_grant;
               end else begin
                  winner_next = m1_req_i;
               end
            end
         end
         ACCESS:  state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Route the winner's request to the RAM and decide whether it is legal.
   always_comb begin
      sel_we    = winner ? m1_we_i   : m0_we_i;
      sel_addr  = winner ? m1_addr_i : m0_addr_i;
      sel_data  = winner ? m1_data_i : m0_data_i;
      sel_valid = (sel_addr[1:0] == 2'b00) && ({2'b00, sel_addr[31:2]} < DEPTH_WORDS);
      in_access = (state == ACCESS);
      capture   = (sel_we || !sel_valid) ? 32'h0 : ram_data_i;
   end

   // RAM port is quiet outside ACCESS; write strobe blocked for bad addresses.
   // Because state is reset asynchronously, asserting rst kills ram_we_o at once.
   always_comb begin
      ram_we_o   = in_access && sel_we && sel_valid;
      ram_addr_o = in_access ? sel_addr : 32'h0;
      ram_data_o = in_access ? sel_data : 32'h0;
   end

   // Ack/err are decoded from RESP so they last exactly one cycle.
   always_comb begin
      m0_ack_o = (state == RESP) && !winner;
      m1_ack_o = (state == RESP) && winner;
      m0_err_o = m0_ack_o && err_q;
      m1_err_o = m1_ack_o && err_q;
   end

   // State, grant history and per-master read-data registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         winner     <= 1'b0;
         last_grant <= 1'b1;
         err_q      <= 1'b0;
         m0_data_o  <= 32'h0;
         m1_data_o  <= 32'h0;
      end else begin
         state  <= state_next;
         winner <= winner_next;
         if (state == ACCESS) begin
            err_q <= !sel_valid;
            if (winner) begin
               m1_data_o <= capture;
            end else begin
               m0_data_o <= capture;
            end
         end
         if (state == RESP) begin
            last_grant <= winner;
         end
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a behavioural RAM on the RAM port, and
// a transaction-level reference (shadow memory plus round-robin bookkeeping).
module tb_ram_arbiter;

   localparam int DEPTH = 4096;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
   logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
   logic [31:0] m0_data_o, m1_data_o;
   logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
   logic        ram_we_o;
   logic [31:0] ram_addr_o, ram_data_o, ram_data_i;

   int checks = 0;
   int passes = 0;

   // Environment RAM and reference shadow memory
   logic [31:0] bram    [0:DEPTH-1];
   logic [31:0] ref_mem [0:DEPTH-1];
   logic        model_last;

   // Results captured by the transaction driver
   int          ack_cyc [2];
   logic        err_seen [2];
   logic [31:0] dat_seen [2];
   int          ack_cnt [2];
   int          early_chg [2];
   int          we_cnt;
   int          err_noack;

   ram_arbiter #(.MEM_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_data_i(m0_wdata),
      .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_data_i(m1_wdata),
      .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
      .ram_data_i(ram_data_i)
   );

   always #5 clk = ~clk;

   // Behavioural RAM: combinational read, synchronous write
   assign ram_data_i = (ram_addr_o[31:14] == 18'h0) ? bram[ram_addr_o[13:2]] : 32'h0;
   always @(posedge clk) begin
      if (ram_we_o && ram_addr_o[31:14] == 18'h0) bram[ram_addr_o[13:2]] <= ram_data_o;
   end

   // Reference: one access applied to the shadow memory
   task automatic model_access(input logic w, input logic [31:0] ad, input logic [31:0] d,
                               output logic e_err, output logic [31:0] e_data);
      logic valid;
      valid  = (ad[1:0] == 2'b00) && (ad[31:2] < DEPTH);
      e_err  = !valid;
      e_data = 32'h0;
      if (valid) begin
         if (w) ref_mem[ad[13:2]] = d;
         else   e_data = ref_mem[ad[13:2]];
      end
   endtask

   // Drive requests from an IDLE cycle, drop each req at its ack, record what happened
   task automatic run_pair(input logic a0, input logic a1, input logic w0, input logic w1,
                           input logic [31:0] ad0, input logic [31:0] ad1,
                           input logic [31:0] d0, input logic [31:0] d1);
      logic [31:0] prev0, prev1;
      m0_req = a0; m0_we = w0; m0_addr = ad0; m0_wdata = d0;
      m1_req = a1; m1_we = w1; m1_addr = ad1; m1_wdata = d1;
      for (int k = 0; k < 2; k++) begin
         ack_cyc[k] = -1; err_seen[k] = 1'b0; dat_seen[k] = 32'h0;
         ack_cnt[k] = 0; early_chg[k] = 0;
      end
      we_cnt = 0; err_noack = 0;
      prev0 = m0_data_o; prev1 = m1_data_o;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         if (ram_we_o) we_cnt++;
         if ((m0_err_o && !m0_ack_o) || (m1_err_o && !m1_ack_o)) err_noack++;
         if (m0_ack_o) begin
            ack_cnt[0]++;
            if (ack_cyc[0] < 0) begin
               ack_cyc[0] = c; err_seen[0] = m0_err_o; dat_seen[0] = m0_data_o;
            end
            m0_req = 1'b0;
         end else if (m0_data_o !== prev0) early_chg[0]++;
         if (m1_ack_o) begin
            ack_cnt[1]++;
            if (ack_cyc[1] < 0) begin
               ack_cyc[1] = c; err_seen[1] = m1_err_o; dat_seen[1] = m1_data_o;
            end
            m1_req = 1'b0;
         end else if (m1_data_o !== prev1) early_chg[1]++;
         prev0 = m0_data_o; prev1 = m1_data_o;
         if ((!a0 || ack_cyc[0] >= 0) && (!a1 || ack_cyc[1] >= 0)) break;
      end
      m0_req = 1'b0; m1_req = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      m0_req = 1'b0; m1_req = 1'b0;
      model_last = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) $display("FAIL reset_ack: got %b%b expected 00", m0_ack_o, m1_ack_o); else passes++;
      checks++; if (m0_err_o !== 1'b0 || m1_err_o !== 1'b0) $display("FAIL reset_err: got %b%b expected 00", m0_err_o, m1_err_o); else passes++;
      checks++; if (m0_data_o !== 32'h0 || m1_data_o !== 32'h0) $display("FAIL reset_data: got %h %h expected 0", m0_data_o, m1_data_o); else passes++;
      checks++; if (ram_we_o !== 1'b0 || ram_addr_o !== 32'h0 || ram_data_o !== 32'h0) $display("FAIL reset_ram: got we=%b a=%h d=%h expected all 0", ram_we_o, ram_addr_o, ram_data_o); else passes++;
      rst = 1'b0;
   endtask

   task automatic test_write_read();
      logic e; logic [31:0] ed;
      model_access(1'b1, 32'h10, 32'hDEADBEEF, e, ed);
      run_pair(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0);
      model_last = 1'b0;
      checks++; if (ack_cyc[0] !== 2) $display("FAIL wr_ack_cycle: got %0d expected 2", ack_cyc[0]); else passes++;
      checks++; if (err_seen[0] !== e) $display("FAIL wr_err: got %b expected %b", err_seen[0], e); else passes++;
      checks++; if (we_cnt !== 1) $display("FAIL wr_we_cycles: got %0d expected 1", we_cnt); else passes++;
      checks++; if (dat_seen[0] !== ed) $display("FAIL wr_data: got %h expected %h", dat_seen[0], ed); else passes++;
      model_access(1'b0, 32'h10, 32'h0, e, ed);
      run_pair(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0);
      model_last = 1'b0;
      checks++; if (ack_cyc[0] !== 2) $display("FAIL rd_ack_cycle: got %0d expected 2", ack_cyc[0]); else passes++;
      checks++; if (dat_seen[0] !== ed) $display("FAIL rd_data: got %h expected %h", dat_seen[0], ed); else passes++;
      checks++; if (we_cnt !== 0 || err_seen[0] !== 1'b0) $display("FAIL rd_we_err: got we=%0d err=%b expected 0 0", we_cnt, err_seen[0]); else passes++;
   endtask

   task automatic test_errors();
      logic [31:0] bad [2];
      logic e; logic [31:0] ed;
      bad[0] = 32'h4000; bad[1] = 32'h3;
      for (int i = 0; i < 2; i++) begin
         model_access(1'b1, bad[i], 32'hCAFEF00D, e, ed);
         run_pair(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, bad[i], 32'h0, 32'hCAFEF00D);
         model_last = 1'b1;
         checks++; if (ack_cyc[1] !== 2 || err_seen[1] !== e) $display("FAIL err_ack: got cyc=%0d err=%b expected cyc=2 err=%b", ack_cyc[1], err_seen[1], e); else passes++;
         checks++; if (we_cnt !== 0) $display("FAIL err_no_write: got %0d expected 0", we_cnt); else passes++;
         checks++; if (dat_seen[1] !== ed) $display("FAIL err_data: got %h expected %h", dat_seen[1], ed); else passes++;
         checks++; if (err_noack !== 0 || ack_cnt[0] !== 0) $display("FAIL err_stray: got errnoack=%0d m0acks=%0d expected 0 0", err_noack, ack_cnt[0]); else passes++;
      end
   endtask

   task automatic test_contention();
      logic e; logic [31:0] ed [2];
      int first;
      do_reset();
      rst = 1'b0;
      for (int r = 0; r < 4; r++) begin
         first = model_last ? 0 : 1;
         model_access(1'b0, 32'h10, 32'h0, e, ed[0]);
         model_access(1'b0, 32'h24, 32'h0, e, ed[1]);
         run_pair(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h24, 32'h0, 32'h0);
         model_last = (first == 0) ? 1'b1 : 1'b0;
         checks++; if (ack_cyc[first] !== 2) $display("FAIL rr_first_%0d: got cyc %0d expected 2 for m%0d", r, ack_cyc[first], first); else passes++;
         checks++; if (ack_cyc[1-first] !== 5) $display("FAIL rr_second_%0d: got cyc %0d expected 5 for m%0d", r, ack_cyc[1-first], 1-first); else passes++;
         checks++; if (dat_seen[0] !== ed[0] || dat_seen[1] !== ed[1]) $display("FAIL rr_data_%0d: got %h %h expected %h %h", r, dat_seen[0], dat_seen[1], ed[0], ed[1]); else passes++;
      end
   endtask

   task automatic test_reset_mid();
      logic e; logic [31:0] ed;
      model_access(1'b1, 32'h20, 32'h12345678, e, ed);
      run_pair(1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h12345678, 32'h0);
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'hBAD0BAD0;
      @(posedge clk); #1;
      checks++; if (ram_we_o !== 1'b1) $display("FAIL mid_access_we: got %b expected 1", ram_we_o); else passes++;
      #2 rst = 1'b1;
      #1;
      checks++; if (ram_we_o !== 1'b0 || ram_addr_o !== 32'h0 || ram_data_o !== 32'h0) $display("FAIL mid_async_ram: got we=%b a=%h d=%h expected all 0", ram_we_o, ram_addr_o, ram_data_o); else passes++;
      checks++; if (m0_data_o !== 32'h0 || m0_ack_o !== 1'b0 || m0_err_o !== 1'b0) $display("FAIL mid_async_m0: got d=%h ack=%b err=%b expected 0", m0_data_o, m0_ack_o, m0_err_o); else passes++;
      @(posedge clk); #1;
      checks++; if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) $display("FAIL mid_no_ack: got %b%b expected 00", m0_ack_o, m1_ack_o); else passes++;
      m0_req = 1'b0; model_last = 1'b1;
      rst = 1'b0;
      @(posedge clk); #1;
      model_access(1'b0, 32'h20, 32'h0, e, ed);
      run_pair(1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 32'h0);
      model_last = 1'b0;
      checks++; if (ack_cyc[0] !== 2 || dat_seen[0] !== ed) $display("FAIL mid_after: got cyc=%0d d=%h expected cyc=2 d=%h", ack_cyc[0], dat_seen[0], ed); else passes++;
   endtask

   task automatic test_drop_req();
      logic e; logic [31:0] ed, prevd;
      model_access(1'b0, 32'h20, 32'h0, e, ed);
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
      prevd = m1_data_o;
      @(posedge clk); #1;
      m1_req = 1'b0;
      checks++; if (m1_ack_o !== 1'b0 || m1_data_o !== prevd) $display("FAIL drop_access: got ack=%b d=%h expected 0 %h", m1_ack_o, m1_data_o, prevd); else passes++;
      @(posedge clk); #1;
      checks++; if (m1_ack_o !== 1'b1 || m1_err_o !== 1'b0) $display("FAIL drop_ack: got ack=%b err=%b expected 1 0", m1_ack_o, m1_err_o); else passes++;
      checks++; if (m1_data_o !== ed) $display("FAIL drop_data: got %h expected %h", m1_data_o, ed); else passes++;
      model_last = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic a [2]; logic w [2]; logic [31:0] ad [2]; logic [31:0] d [2];
      logic e_err [2]; logic [31:0] e_dat [2]; int e_cyc [2];
      int first, exp_we, r;
      for (int it = 0; it < 24; it++) begin
         for (int k = 0; k < 2; k++) begin
            a[k] = 1'($urandom_range(0, 1));
            w[k] = 1'($urandom_range(0, 1));
            d[k] = $urandom;
            r = $urandom_range(0, 7);
            if (r == 0)      ad[k] = 32'($urandom_range(4096, 8000)) << 2;
            else if (r == 1) ad[k] = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
            else             ad[k] = 32'($urandom_range(0, 15)) << 2;
            e_cyc[k] = -1; e_err[k] = 1'b0; e_dat[k] = 32'h0;
         end
         if (!a[0] && !a[1]) a[it % 2] = 1'b1;
         first = (a[0] && a[1]) ? (model_last ? 0 : 1) : (a[0] ? 0 : 1);
         exp_we = 0;
         model_access(w[first], ad[first], d[first], e_err[first], e_dat[first]);
         e_cyc[first] = 2;
         if (w[first] && !e_err[first]) exp_we++;
         model_last = 1'(first);
         if (a[1-first]) begin
            model_access(w[1-first], ad[1-first], d[1-first], e_err[1-first], e_dat[1-first]);
            e_cyc[1-first] = 5;
            if (w[1-first] && !e_err[1-first]) exp_we++;
            model_last = 1'(1 - first);
         end
         run_pair(a[0], a[1], w[0], w[1], ad[0], ad[1], d[0], d[1]);
         for (int k = 0; k < 2; k++) begin
            checks++; if (ack_cyc[k] !== e_cyc[k] || ack_cnt[k] !== (a[k] ? 1 : 0)) $display("FAIL rand%0d_m%0d_ack: got cyc=%0d n=%0d expected cyc=%0d", it, k, ack_cyc[k], ack_cnt[k], e_cyc[k]); else passes++;
            if (a[k]) begin
               checks++; if (err_seen[k] !== e_err[k] || dat_seen[k] !== e_dat[k]) $display("FAIL rand%0d_m%0d_resp: got err=%b d=%h expected err=%b d=%h", it, k, err_seen[k], dat_seen[k], e_err[k], e_dat[k]); else passes++;
            end
            checks++; if (early_chg[k] !== 0) $display("FAIL rand%0d_m%0d_hold: got %0d changes expected 0", it, k, early_chg[k]); else passes++;
         end
         checks++; if (we_cnt !== exp_we || err_noack !== 0) $display("FAIL rand%0d_we: got we=%0d errnoack=%0d expected we=%0d 0", it, we_cnt, err_noack, exp_we); else passes++;
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         bram[i] = 32'h0;
         ref_mem[i] = 32'h0;
      end
      model_last = 1'b1;
      $display("[TB] ram_arbiter bench starting");
      test_reset();
      @(posedge clk); #1;
      test_write_read();
      test_errors();
      test_contention();
      test_reset_mid();
      test_drop_req();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 4096, meaning the number of 32-bit words in the attached RAM.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  asynchronous reset, active-high.
REQ-005 m0_req_i  input  1  master 0 (core data port) request.
REQ-006 m0_we_i  input  1  master 0 write enable (1 = write, 0 = read).
REQ-007 m0_addr_i  input  32  master 0 byte address.
REQ-008 m0_data_i  input  32  master 0 write data.
REQ-009 m0_data_o  output  32  master 0 read data, registered.
REQ-010 m0_ack_o  output  1  master 0 one-cycle completion pulse.
REQ-011 m0_err_o  output  1  master 0 error flag, valid with m0_ack_o.
REQ-012 m1_req_i, m1_we_i, m1_addr_i, m1_data_i, m1_data_o, m1_ack_o, m1_err_o SHALL have the same directions, widths and meanings for master 1 (debug/loader port).
REQ-013 ram_we_o  output  1  RAM write enable.
REQ-014 ram_addr_o  output  32  RAM byte address; the RAM indexes words with addr[31:2].
REQ-015 ram_data_o  output  32  RAM write data.
REQ-016 ram_data_i  input  32  RAM combinational read data.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-018 IDLE: if any req_i is high, the block SHALL latch the winner id and go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-019 Arbitration SHALL be round-robin: on a tie, grant the master not served last; last_grant resets to 1, so m0 wins the first tie; a single requester always wins.
REQ-020 ACCESS SHALL drive ram_addr_o and ram_data_o from the winner, and drive ram_we_o = winner we AND valid.
REQ-021 In ACCESS, read data SHALL be captured from ram_data_i into the winner's data_o register; for a write or an invalid access, the capture value SHALL be 0.
REQ-022 A request SHALL be valid only if addr[1:0] == 0 and addr[31:2] < MEM_DEPTH.
REQ-023 An invalid request SHALL NOT write the RAM and SHALL set err_o = 1 with its ack.
REQ-024 RESP SHALL pulse the winner's ack_o for exactly one cycle, drive err_o for that cycle, update last_grant to the winner, and then go to IDLE.
REQ-025 Latency: a request seen in IDLE at cycle N SHALL be acked at cycle N+2; peak throughput SHALL be one access per 3 cycles.
REQ-026 The loser's request SHALL be held pending, with no ack, and served in the next IDLE cycle.
REQ-027 Outside ACCESS, ram_we_o, ram_addr_o and ram_data_o SHALL be 0.
REQ-028 A master SHALL hold its req, we, addr and data stable until its ack.
REQ-029 A master SHALL drop req or present a new request in the cycle after its ack; req high in IDLE SHALL be treated as a new request.
REQ-030 If req drops mid-transaction, the transaction SHALL still complete and ack.
REQ-031 data_o SHALL change only in the cycle that raises its own master's ack; otherwise it SHALL hold.
REQ-032 err_o SHALL be 0 whenever ack_o is 0.
REQ-033 ram_we_o SHALL be high for at most one cycle per transaction.

Reset
REQ-034 While rst = 1: state = IDLE, last_grant = 1, all ack_o, err_o, data_o and ram_* outputs = 0.
REQ-035 Reset asserted mid-transaction SHALL force ram_we_o low immediately (asynchronously); the pending access SHALL be dropped with no ack and no write.
REQ-036 On the first edge after rst falls, the block SHALL sample requests from IDLE.

Verification
REQ-037 m0 write 0xDEADBEEF to 0x10, then m0 read 0x10 -> first ack at N+2 with err 0; read data_o = 0xDEADBEEF; ram_we_o high exactly one cycle.
REQ-038 m0 and m1 both request reads from reset -> m0 acked first, m1 acked 3 cycles later; with both held, grants alternate m0, m1, m0, ...
REQ-039 m1 write to 0x4000 (word 4096) and m1 write to 0x3 -> err_o = 1 with ack, ram_we_o never high, data_o = 0.
REQ-040 rst pulsed during ACCESS of an m0 write -> no ack, RAM word unchanged, all outputs 0, next request served normally.
REQ-041 m1 drops req during ACCESS -> ack still issued at N+2; m1 data_o updated only in the ack cycle.
